sensor_height_acq: RTL
======================

Name: sensor_height_acq

Overview:
Upstream acquisition stage for the baggage-drop height path. Samples the four 8-bit distance sensors on a strobe and computes a per-sample height with a pair-selection rule. Averages AVG_DEPTH accepted samples and presents one filtered height to the square-root/timing path over a valid/ready handshake. Replaces the raw, unfiltered combinational height feed with a registered, noise-reduced value.

Parameters:
W, 8, sensor and height width in bits
AVG_DEPTH, 4, accepted samples per output; power of 2, range 2..16

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
sample_valid  in  1  sensor1..4 hold a new sample this cycle
sensor1  in  W  sensor 1 reading, 0 = faulty/no echo
sensor2  in  W  sensor 2 reading, 0 = faulty
sensor3  in  W  sensor 3 reading, 0 = faulty
sensor4  in  W  sensor 4 reading, 0 = faulty
height  out  W  filtered height; stable while height_valid=1
height_valid  out  1  height available to downstream
height_ready  in  1  downstream accepts height
sensor_fault  out  1  1-cycle pulse: sample rejected (no usable pair)
sample_dropped  out  1  1-cycle pulse: valid sample arrived while in HOLD

Behaviour:
- Reset (clk edge with rst=1): state=COLLECT, count=0, acc=0, height=0, height_valid=0, sensor_fault=0, sample_dropped=0. Reset mid-operation discards the partial accumulation and any pending output.
- Per-sample height (combinational):
  - s1==0 or s3==0 -> (s2+s4+1)>>1.
  - Else if s2==0 or s4==0 -> (s1+s3+1)>>1.
  - Else (s1+s2+s3+s4+2)>>2.
  - Pair sums use W+1 bits, quad sum W+2 bits; no overflow.
- Rejection: (s1==0 or s3==0) and (s2==0 or s4==0) -> sample rejected. sensor_fault pulses the next cycle; count and acc are unchanged.
- States: COLLECT and HOLD.
  - COLLECT, sample_valid=1, sample not rejected: acc += per-sample height; count += 1.
  - On the AVG_DEPTH-th accepted sample:
    - height <= (acc_final + AVG_DEPTH/2) >> log2(AVG_DEPTH), where acc_final includes that sample.
    - height_valid <= 1; acc, count <= 0; state <= HOLD.
  - Latency: height_valid rises the cycle after the last accepted sample is presented.
  - Accumulator width: W + log2(AVG_DEPTH).
  - HOLD: height and height_valid are held.
    - height_valid && height_ready -> height_valid <= 0, state <= COLLECT next cycle.
    - Any sample_valid in HOLD, including the handshake cycle, is discarded. sample_dropped pulses the next cycle. A rejected sample in HOLD raises sample_dropped only; sensor_fault stays 0.
- height_valid never drops without height_ready (AXI-style rule). height_ready is ignored while height_valid=0.
- Pulse outputs are registered and last exactly one cycle per causing sample.

Decomposition:
- Shared package baggage_pkg:
  - state enum {COLLECT, HOLD}
  - W default and AVG_DEPTH default
  - log2 helper constant function
- Sub-module sensor_pair_height: purely combinational.
  - Inputs: s1..s4. Outputs: sample_height[W-1:0], reject.
  - Reusable by other height consumers.

Test Plan:
1. AVG_DEPTH=4. Four samples (10,20,30,40), one per cycle, ready=1 -> after the 4th sample, height_valid=1 next cycle with height=25. Handshake completes the same cycle, then state returns to COLLECT.
2. Samples with per-sample heights 25,25,26,26 (quad inputs like 25,25,25,25 / 26,26,26,26) -> sum 102, height=(102+2)>>2=26.
3. Pair fallback: s1=0,s2=20,s3=99,s4=41 -> per-sample 31. s2=0,s1=7,s3=8 -> per-sample 8. Four fallback samples of 31 -> height=31.
4. Fault: s1=0,s2=0 -> sensor_fault pulses one cycle, count unchanged. The next 4 good samples still yield exactly one output.
5. Back-pressure: height_ready=0 for 10 cycles with samples arriving -> height stable, height_valid held, sample_dropped pulses once per sample. Raising ready -> one transfer; accumulation restarts from zero.
6. Reset after 3 accepted samples -> all outputs 0. The next 4 samples (200 each) give height=200, with no contribution from the pre-reset samples.

Source files
------------

// File: rtl/baggage_pkg.sv
// Shared definitions for the baggage-drop height path.
//   state_t          : acquisition FSM states
//   W_DEF            : default sensor/height width
//   AVG_DEPTH_DEF    : default number of accepted samples per output
//   log2_ceil()      : elaboration-time ceiling log2 helper
package baggage_pkg;

    localparam int unsigned W_DEF         = 8;
    localparam int unsigned AVG_DEPTH_DEF = 4;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Ceiling log2 for parameter sizing; exact for powers of two.
    function automatic int unsigned log2_ceil(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sensor_pair_height.sv
// Combinational per-sample height from four distance sensors.
// A reading of 0 marks a faulty sensor. Sensors 1/3 and 2/4 form opposing
// pairs; a pair with a faulty member is excluded, and when both pairs are
// unusable the sample is rejected.
//   s1..s4        in  : sensor readings
//   sample_height out : rounded mean of the usable sensors
//   reject        out : no usable pair in this sample
module sensor_pair_height
    import baggage_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0] s1,
    input  logic [W-1:0] s2,
    input  logic [W-1:0] s3,
    input  logic [W-1:0] s4,
    output logic [W-1:0] sample_height,
    output logic         reject
);

    logic [W:0]   sum13;
    logic [W:0]   sum24;
    logic [W+1:0] sum_all;
    logic         bad13;
    logic         bad24;

    always_comb begin
        bad13   = (s1 == '0) || (s3 == '0);
        bad24   = (s2 == '0) || (s4 == '0);
        // Rounding constants folded into the sums; widths leave headroom.
        sum13   = (W+1)'(s1) + (W+1)'(s3) + (W+1)'(1);
        sum24   = (W+1)'(s2) + (W+1)'(s4) + (W+1)'(1);
        sum_all = (W+2)'(s1) + (W+2)'(s2) + (W+2)'(s3) + (W+2)'(s4) + (W+2)'(2);

        reject = bad13 && bad24;
        if (bad13) begin
            sample_height = W'(sum24 >> 1);
        end else if (bad24) begin
            sample_height = W'(sum13 >> 1);
        end else begin
            sample_height = W'(sum_all >> 2);
        end
    end

endmodule

// File: rtl/sensor_height_acq.sv
// Height acquisition: samples four sensors on sample_valid, averages
// AVG_DEPTH accepted per-sample heights and offers the rounded mean over a
// valid/ready handshake.
//   clk, rst        : clock, synchronous active-high reset
//   sample_valid    : sensor1..4 carry a new sample
//   sensor1..4      : raw sensor readings (0 = faulty)
//   height          : filtered height, stable while height_valid
//   height_valid    : height offered downstream
//   height_ready    : downstream accepts height
//   sensor_fault    : 1-cycle pulse, sample rejected in COLLECT
//   sample_dropped  : 1-cycle pulse, sample arrived while holding output
module sensor_height_acq
    import baggage_pkg::*;
#(
    parameter int unsigned W         = W_DEF,
    parameter int unsigned AVG_DEPTH = AVG_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_valid,
    input  logic [W-1:0] sensor1,
    input  logic [W-1:0] sensor2,
    input  logic [W-1:0] sensor3,
    input  logic [W-1:0] sensor4,
    output logic [W-1:0] height,
    output logic         height_valid,
    input  logic         height_ready,
    output logic         sensor_fault,
    output logic         sample_dropped
);

    localparam int unsigned LOG2  = log2_ceil(AVG_DEPTH);
    localparam int unsigned ACC_W = W + LOG2;
    localparam int unsigned CNT_W = (LOG2 > 0) ? LOG2 : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [W-1:0]       height_q, height_d;
    logic               height_valid_q, height_valid_d;
    logic               sensor_fault_q, sensor_fault_d;
    logic               sample_dropped_q, sample_dropped_d;

    logic [W-1:0]       sample_height;
    logic               reject;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   avg_round;

    sensor_pair_height #(.W(W)) u_pair (
        .s1            (sensor1),
        .s2            (sensor2),
        .s3            (sensor3),
        .s4            (sensor4),
        .sample_height (sample_height),
        .reject        (reject)
    );

    // Next-state and output logic.
    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        acc_d            = acc_q;
        height_d         = height_q;
        height_valid_d   = height_valid_q;
        sensor_fault_d   = 1'b0;
        sample_dropped_d = 1'b0;

        // Accumulator width covers AVG_DEPTH full-scale samples plus rounding.
        acc_sum   = acc_q + ACC_W'(sample_height);
        avg_round = acc_sum + ACC_W'(AVG_DEPTH / 2);

        case (state_q)
            COLLECT: begin
                if (sample_valid) begin
                    if (reject) begin
                        sensor_fault_d = 1'b1;
                    end else if (count_q == CNT_W'(AVG_DEPTH - 1)) begin
                        height_d       = W'(avg_round >> LOG2);
                        height_valid_d = 1'b1;
                        acc_d          = '0;
                        count_d        = '0;
                        state_d        = HOLD;
                    end else begin
                        acc_d   = acc_sum;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // Samples are discarded while an output is pending, even on
                // the handshake cycle; no fault is flagged here.
                if (sample_valid) begin
                    sample_dropped_d = 1'b1;
                end
                if (height_valid_q && height_ready) begin
                    height_valid_d = 1'b0;
                    state_d        = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= COLLECT;
            count_q          <= '0;
            acc_q            <= '0;
            height_q         <= '0;
            height_valid_q   <= 1'b0;
            sensor_fault_q   <= 1'b0;
            sample_dropped_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            acc_q            <= acc_d;
            height_q         <= height_d;
            height_valid_q   <= height_valid_d;
            sensor_fault_q   <= sensor_fault_d;
            sample_dropped_q <= sample_dropped_d;
        end
    end

    assign height         = height_q;
    assign height_valid   = height_valid_q;
    assign sensor_fault   = sensor_fault_q;
    assign sample_dropped = sample_dropped_q;

endmodule
